pipe_slice: RTL
===============

# pipe_slice

Generic, parametrised pipeline-register slice with a valid/ready handshake on both sides. It replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/LS, LS/WB) with one block carrying an opaque payload vector of WIDTH bits. It adds three things the per-stage registers lack: an optional two-entry skid buffer that makes `in_ready_o` a pure register output, a synchronous flush, and reset of the payload. Each stage boundary instantiates one slice and packs its fields into `in_data_i`.

## Interface
- `WIDTH`, default 64: payload width in bits, ≥1.
- `SKID`, default 1. 1 = two-entry skid buffer with registered `in_ready_o`; 0 = single register with combinational ready.
- `RST_VAL`, default '0: payload register reset value (WIDTH bits).

- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-low.
- `flush_i`  in  1  synchronous kill of all held beats.
- `in_valid_i`  in  1  upstream beat valid.
- `in_ready_o`  out  1  slice can accept a beat.
- `in_data_i`  in  WIDTH  upstream payload.
- `out_valid_o`  out  1  slice holds a beat for downstream.
- `out_ready_i`  in  1  downstream accepts.
- `out_data_o`  out  WIDTH  held payload.

## Operation
- Handshake and fire definitions:
  - in_fire = `in_valid_i & in_ready_o`.
  - out_fire = `out_valid_o & out_ready_i`.
- Storage:
  - Main register M: always drives `out_data_o`.
  - Skid register S: only present when SKID=1.
- FSM for SKID=1; state register is 2 bits, states EMPTY, BUSY, FULL:
  - EMPTY: `out_valid_o`=0, `in_ready_o`=1. On in_fire: M<=in, go to BUSY.
  - BUSY: `out_valid_o`=1, `in_ready_o`=1.
    - in_fire & out_fire: M<=in, stay in BUSY.
    - in_fire & !out_fire: S<=in, go to FULL.
    - !in_fire & out_fire: go to EMPTY.
    - Otherwise hold.
  - FULL: `out_valid_o`=1, `in_ready_o`=0. On out_fire: M<=S, go to BUSY.
  - `in_ready_o` is a flop: it is 0 exactly when the next state is FULL.
- SKID=0:
  - One valid flop V.
  - `in_ready_o` = !V | `out_ready_i` (combinational).
  - On in_fire: M<=in, V<=1. Otherwise on out_fire: V<=0.
- Flush:
  - `flush_i`=1 forces the next state to EMPTY (V<=0).
  - Flush overrides every other transition.
  - A beat accepted in the flush cycle is discarded.
  - `out_valid_o` is not masked combinationally. A beat consumed by downstream in the flush cycle counts as delivered.
  - M and S keep their contents; they are don't-care while EMPTY.
- Reset (`rst_i`=0 at an edge):
  - State goes to EMPTY / V<=0. M and S load RST_VAL.
  - Overrides flush and all handshakes.
  - Reset mid-FULL drops both beats.
- Stability guarantee: while `out_valid_o`=1 and `out_ready_i`=0, `out_valid_o` and `out_data_o` do not change, except under flush or reset.
- Payload is opaque. No arithmetic on it; widths pass through unchanged.

## Timing
- Values after reset:
  - `out_valid_o`=0.
  - `out_data_o`=RST_VAL.
  - `in_ready_o`=1 (both SKID modes; in SKID=0, ready is 1 because V=0).
- Latency: a beat accepted at edge N is visible on `out_*` in cycle N+1.
- Throughput: 1 beat/cycle sustained when `out_ready_i` is held at 1, in both modes.
- SKID=1:
  - No combinational path from any input to any output.
  - Absorbs one extra beat when downstream stalls.
  - After a stall releases, `in_ready_o` rises one cycle after the out_fire that drains S.
- SKID=0: combinational path `out_ready_i` → `in_ready_o`. Single-entry capacity.
- Data ordering is strict FIFO; no beat is duplicated or reordered.

## Structure
- Shared package `pipe_pkg` holds:
  - typedef enum logic [1:0] `slice_state_t` {EMPTY, BUSY, FULL}.
  - Localparams for the per-stage payload widths of each stage boundary.
- Single module. The generate branch on SKID selects the FSM or the V-flop path.
- No sub-module is needed. Stage wrappers only pack and unpack their fields into `in_data_i` / `out_data_o`.

## Test plan
- Reset, then idle: `out_valid_o`=0, `out_data_o`=RST_VAL, `in_ready_o`=1. With SKID=1, state is EMPTY.
- Streaming: send 0x1..0x10 back-to-back with `out_ready_i`=1. Outputs are 0x1..0x10 in consecutive cycles, starting 1 cycle after the first accept; `in_ready_o` stays 1.
- Stall (SKID=1):
  - Send 0xA then 0xB with `out_ready_i`=0.
  - After 0xB, `in_ready_o`=0 and `out_data_o` holds 0xA.
  - Release: 0xA, then 0xB, each delivered once; `in_ready_o` returns to 1 one cycle after 0xA is delivered.
- Flush in FULL: with 0xA/0xB held, assert `flush_i` for 1 cycle while offering 0xC. Next cycle `out_valid_o`=0 and nothing is delivered afterwards.
- Mid-operation reset: in FULL, drive `rst_i`=0 for 1 cycle. Next cycle `out_valid_o`=0, `out_data_o`=RST_VAL, `in_ready_o`=1.
- SKID=0, random valid/ready over 10k cycles:
  - Scoreboard: no loss, duplication or reordering.
  - `in_ready_o` equals !V | `out_ready_i` every cycle.

Source files
------------

// File: rtl/pipe_slice_pkg.sv
// Shared types and per-boundary payload widths for the pipeline register slices.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pipe_pkg;

   // Occupancy states of a skid-buffered slice
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } slice_state_t;

   // Payload widths packed by each stage-boundary wrapper
   localparam int unsigned IF_ID_W = 64;
   localparam int unsigned ID_EX_W = 128;
   localparam int unsigned EX_LS_W = 96;
   localparam int unsigned LS_WB_W = 48;

endpackage

// File: rtl/pipe_slice.sv
// Generic valid/ready pipeline register slice carrying an opaque WIDTH-bit payload.
// Latency: a beat accepted at edge N is presented on out_* in cycle N+1.
// Backpressure: SKID=1 absorbs one extra beat with a registered in_ready_o; SKID=0 passes out_ready_i to in_ready_o.
module pipe_slice
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH   = 64,
   parameter int unsigned      SKID    = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o
);

   generate
      if (SKID != 0) begin : g_skid
         slice_state_t     r_state;
         slice_state_t     w_next;
         logic             r_out_valid;
         logic             r_in_ready;
         logic [WIDTH-1:0] r_m;
         logic [WIDTH-1:0] r_s;
         logic             w_in_fire;
         logic             w_out_fire;

         assign w_in_fire  = in_valid_i & r_in_ready;
         assign w_out_fire = r_out_valid & out_ready_i;

         // Next occupancy state; flush empties the slice regardless of handshakes
         always_comb begin
            w_next = r_state;
            case (r_state)
               EMPTY: if (w_in_fire) w_next = BUSY;
               BUSY: begin
                  if (w_in_fire && !w_out_fire)      w_next = FULL;
                  else if (!w_in_fire && w_out_fire) w_next = EMPTY;
               end
               FULL: if (w_out_fire) w_next = BUSY;
               default: w_next = EMPTY;
            endcase
            if (flush_i) w_next = EMPTY;
         end

         // State, registered handshake outputs and payload movement between M and S
         always_ff @(posedge clk_i) begin
            if (!rst_i) begin
               r_state     <= EMPTY;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_m         <= RST_VAL;
               r_s         <= RST_VAL;
            end else begin
               r_state     <= w_next;
               r_out_valid <= (w_next != EMPTY);
               r_in_ready  <= (w_next != FULL);
               // Under flush the registers keep stale contents; they are ignored while EMPTY
               if (!flush_i) begin
                  case (r_state)
                     EMPTY: if (w_in_fire) r_m <= in_data_i;
                     BUSY: begin
                        if (w_in_fire) begin
                           if (w_out_fire) r_m <= in_data_i;
                           else            r_s <= in_data_i;
                        end
                     end
                     FULL: if (w_out_fire) r_m <= r_s;
                     default: ;
                  endcase
               end
            end
         end

         assign in_ready_o  = r_in_ready;
         assign out_valid_o = r_out_valid;
         assign out_data_o  = r_m;
      end else begin : g_noskid
         logic             r_v;
         logic [WIDTH-1:0] r_m;
         logic             w_in_ready;
         logic             w_in_fire;
         logic             w_out_fire;

         assign w_in_ready = !r_v | out_ready_i;
         assign w_in_fire  = in_valid_i & w_in_ready;
         assign w_out_fire = r_v & out_ready_i;

         // Single-entry holding register; a new beat may replace one leaving this cycle
         always_ff @(posedge clk_i) begin
            if (!rst_i) begin
               r_v <= 1'b0;
               r_m <= RST_VAL;
            end else if (flush_i) begin
               r_v <= 1'b0;
            end else if (w_in_fire) begin
               r_v <= 1'b1;
               r_m <= in_data_i;
            end else if (w_out_fire) begin
               r_v <= 1'b0;
            end
         end

         assign in_ready_o  = w_in_ready;
         assign out_valid_o = r_v;
         assign out_data_o  = r_m;
      end
   endgenerate

endmodule
